// File: rtl/impl_chk_pkg.sv
// Shared types and default widths for the implication checker.
package impl_chk_pkg;

  typedef enum logic [1:0] {
    CLEAN   = 2'd0,
    PASSING = 2'd1,
    FAILED  = 2'd2
  } chk_status_e;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned TS_W_DEF  = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: hold at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/impl_checker.sv
// Hardware checker for "a |-> ##DELAY b" with per-attempt pulses,
// saturating statistics and a timestamp of the first failing launch.
//
// state   | meaning
// CLEAN   | no attempt has matured since rst/clr
// PASSING | at least one pass, no fail since rst/clr
// FAILED  | a fail has occurred; held until rst/clr
module impl_checker
  import impl_chk_pkg::*;
#(
  parameter int unsigned DELAY = 1,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned TS_W  = TS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output chk_status_e      status,
  output logic [CNT_W-1:0] attempt_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [TS_W-1:0]  first_fail_ts,
  output logic             first_fail_vld,
  output logic [TS_W-1:0]  cyc_cnt
);

  logic [DELAY-1:0] pend_q, pend_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [TS_W-1:0]  cyc_q, cyc_d;
  logic [TS_W-1:0]  ffts_q, ffts_d;
  logic             ffv_q, ffv_d;
  chk_status_e      state_q, state_d;

  logic launch;
  logic mature;

  assign launch = en & a;
  assign mature = pend_q[DELAY-1];

  // Pipe shift, verdicts, timestamp capture; clr suppresses everything.
  always_comb begin
    pend_d    = pend_q << 1;
    pend_d[0] = launch;
    if (clr) begin
      pend_d = '0;
    end
    pass_d = mature & b & ~clr;
    fail_d = mature & ~b & ~clr;
    cyc_d  = cyc_q + TS_W'(1);
    ffts_d = ffts_q;
    ffv_d  = ffv_q;
    if (clr) begin
      ffts_d = '0;
      ffv_d  = 1'b0;
    end else if (fail_d && !ffv_q) begin
      // cyc_q is the stamp of this maturity edge; the launch was DELAY earlier.
      ffts_d = cyc_q - TS_W'(DELAY);
      ffv_d  = 1'b1;
    end
  end

  // Status FSM next state; FAILED only leaves on clr.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = CLEAN;
    end else begin
      case (state_q)
        CLEAN: begin
          if (fail_d)      state_d = FAILED;
          else if (pass_d) state_d = PASSING;
        end
        PASSING: begin
          if (fail_d) state_d = FAILED;
        end
        FAILED:  state_d = FAILED;
        default: state_d = CLEAN;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      cyc_q   <= '0;
      ffts_q  <= '0;
      ffv_q   <= 1'b0;
      state_q <= CLEAN;
    end else begin
      pend_q  <= pend_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      cyc_q   <= cyc_d;
      ffts_q  <= ffts_d;
      ffv_q   <= ffv_d;
      state_q <= state_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_attempt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr),
    .inc_i (launch & ~clr),
    .cnt_o (attempt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_pass (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr),
    .inc_i (pass_d),
    .cnt_o (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr),
    .inc_i (fail_d),
    .cnt_o (fail_cnt)
  );

  assign pass_pulse     = pass_q;
  assign fail_pulse     = fail_q;
  assign status         = state_q;
  assign first_fail_ts  = ffts_q;
  assign first_fail_vld = ffv_q;
  assign cyc_cnt        = cyc_q;

endmodule
